// File: rtl/axis_isp_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : axis_isp_pkg
// Brief    : Shared constants and state encoding for the ISP frame gate.
// Revision : 1.0 - initial release
// ============================================================================
package axis_isp_pkg;

    localparam int DEF_IDX_W   = 12;
    localparam int FRAME_CNT_W = 16;
    localparam int STATE_W     = 3;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t S_IDLE = 3'b001;
    localparam state_t S_PASS = 3'b010;
    localparam state_t S_DROP = 3'b100;

endpackage
`default_nettype wire

// File: rtl/axis_xy_tracker.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : axis_xy_tracker
// Brief    : Pixel/line position counters and the frame-geometry shadows.
// Revision : 1.0 - initial release
// ============================================================================
module axis_xy_tracker
    import axis_isp_pkg::*;
#(
    parameter int IDX_W = DEF_IDX_W
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             hs,
    input  logic             tlast,
    input  logic             load,
    input  logic [IDX_W-1:0] max_x_index,
    input  logic [IDX_W-1:0] max_y_index,
    output logic             x_at_max,
    output logic             y_at_max,
    output logic             x_zero_y_zero,
    output logic [IDX_W-1:0] cur_max_y_index
);

    localparam logic [IDX_W-1:0] c_one = IDX_W'(1);

    logic [IDX_W-1:0] r_x;
    logic [IDX_W-1:0] r_y;
    logic [IDX_W-1:0] r_max_x;
    logic [IDX_W-1:0] r_max_y;

    // x never passes the shadow width: the long-line check stops the frame first
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_x     <= '0;
            r_y     <= '0;
            r_max_x <= '0;
            r_max_y <= '0;
        end else if (load) begin
            r_x     <= '0;
            r_y     <= '0;
            r_max_x <= max_x_index;
            r_max_y <= max_y_index;
        end else if (hs) begin
            if (tlast) begin
                r_x <= '0;
                if (!y_at_max) begin
                    r_y <= r_y + c_one;
                end
            end else if (!x_at_max) begin
                r_x <= r_x + c_one;
            end
        end
    end

    assign x_at_max        = (r_x == r_max_x);
    assign y_at_max        = (r_y == r_max_y);
    assign x_zero_y_zero   = (r_x == '0) && (r_y == '0);
    assign cur_max_y_index = r_max_y;

endmodule
`default_nettype wire

// File: rtl/axis_frame_gate_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : axis_frame_gate_ctrl
// Brief    : Admits whole AXIS frames only, checks geometry, drops bad frames.
// Revision : 1.0 - initial release
// ============================================================================
module axis_frame_gate_ctrl
    import axis_isp_pkg::*;
#(
    parameter int BITS  = 8,
    parameter int IDX_W = DEF_IDX_W
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic                   enable,
    input  logic [IDX_W-1:0]       max_x_index,
    input  logic [IDX_W-1:0]       max_y_index,
    input  logic [BITS-1:0]        s_axis_tdata,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic                   s_axis_tlast,
    input  logic                   s_axis_tuser,
    output logic [BITS-1:0]        m_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tlast,
    output logic                   m_axis_tuser,
    output logic [IDX_W-1:0]       cur_max_y_index,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   err_short_line,
    output logic                   err_long_line,
    output logic                   err_sof,
    output logic [FRAME_CNT_W-1:0] frame_count
);

    localparam logic [FRAME_CNT_W-1:0] c_cnt_one = FRAME_CNT_W'(1);

    state_t r_state;
    state_t w_next_state;

    logic w_x_at_max;
    logic w_y_at_max;
    logic w_xy_zero;
    logic w_in_pass;
    logic w_sof_arm;
    logic w_kill;
    logic w_hs;
    logic w_pass_hs;
    logic w_load;
    logic w_ev_short;
    logic w_ev_long;
    logic w_ev_end;
    logic w_good_end;

    logic                   r_frame_bad;
    logic                   r_frame_done;
    logic                   r_err_short;
    logic                   r_err_long;
    logic                   r_err_sof;
    logic [FRAME_CNT_W-1:0] r_frame_count;

    assign w_in_pass = (r_state == S_PASS);
    assign w_sof_arm = s_axis_tvalid & s_axis_tuser & enable;
    // A SOF anywhere but the first pixel aborts the frame; the beat stays on the bus
    assign w_kill    = w_in_pass & s_axis_tvalid & s_axis_tuser & ~w_xy_zero;
    assign w_hs      = s_axis_tvalid & s_axis_tready;
    assign w_pass_hs = w_hs & w_in_pass;
    assign w_load    = ~w_in_pass & w_sof_arm;

    assign w_ev_short = w_pass_hs &  s_axis_tlast & ~w_x_at_max;
    assign w_ev_long  = w_pass_hs & ~s_axis_tlast &  w_x_at_max;
    assign w_ev_end   = w_pass_hs &  s_axis_tlast &  w_y_at_max;
    // Any short line disqualifies the frame from being counted as good
    assign w_good_end = w_ev_end & ~w_ev_short & ~r_frame_bad;

    axis_xy_tracker #(
        .IDX_W (IDX_W)
    ) u_xy_tracker (
        .aclk            (aclk),
        .areset          (areset),
        .hs              (w_pass_hs),
        .tlast           (s_axis_tlast),
        .load            (w_load),
        .max_x_index     (max_x_index),
        .max_y_index     (max_y_index),
        .x_at_max        (w_x_at_max),
        .y_at_max        (w_y_at_max),
        .x_zero_y_zero   (w_xy_zero),
        .cur_max_y_index (cur_max_y_index)
    );

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE, S_DROP: begin
                if (w_load) begin
                    w_next_state = S_PASS;
                end
            end
            S_PASS: begin
                if (w_kill || w_ev_long) begin
                    w_next_state = S_DROP;
                end else if (w_ev_end) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_comb begin
        s_axis_tready = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        case (r_state)
            S_PASS: begin
                m_axis_tvalid = s_axis_tvalid & ~w_kill;
                s_axis_tready = m_axis_tready & ~w_kill;
                m_axis_tlast  = s_axis_tlast | w_x_at_max;
            end
            default: begin
                // Non-SOF beats are discarded; an admissible SOF is held for one stall
                s_axis_tready = ~w_sof_arm;
            end
        endcase
        if (areset) begin
            s_axis_tready = 1'b0;
            m_axis_tvalid = 1'b0;
        end
    end

    assign m_axis_tdata = s_axis_tdata;
    assign m_axis_tuser = s_axis_tuser;

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_frame_bad   <= 1'b0;
            r_frame_done  <= 1'b0;
            r_err_short   <= 1'b0;
            r_err_long    <= 1'b0;
            r_err_sof     <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_frame_done <= w_good_end;
            r_err_short  <= w_ev_short;
            r_err_long   <= w_ev_long;
            r_err_sof    <= w_kill;
            if (w_load) begin
                r_frame_bad <= 1'b0;
            end else if (w_ev_short) begin
                r_frame_bad <= 1'b1;
            end
            if (w_good_end) begin
                r_frame_count <= r_frame_count + c_cnt_one;
            end
        end
    end

    assign busy           = w_in_pass;
    assign frame_done     = r_frame_done;
    assign err_short_line = r_err_short;
    assign err_long_line  = r_err_long;
    assign err_sof        = r_err_sof;
    assign frame_count    = r_frame_count;

endmodule
`default_nettype wire

// File: tb/tb_axis_frame_gate_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_axis_frame_gate_ctrl
// Brief    : Self-checking bench for axis_frame_gate_ctrl with a stream model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_frame_gate_ctrl;

    localparam int BITS  = 8;
    localparam int IDX_W = 12;

    typedef struct packed {
        logic [BITS-1:0] d;
        logic            l;
        logic            u;
    } beat_t;

    logic             aclk = 1'b0;
    logic             areset;
    logic             enable;
    logic [IDX_W-1:0] max_x_index;
    logic [IDX_W-1:0] max_y_index;
    logic [BITS-1:0]  s_axis_tdata;
    logic             s_axis_tvalid;
    logic             s_axis_tready;
    logic             s_axis_tlast;
    logic             s_axis_tuser;
    logic [BITS-1:0]  m_axis_tdata;
    logic             m_axis_tvalid;
    logic             m_axis_tready;
    logic             m_axis_tlast;
    logic             m_axis_tuser;
    logic [IDX_W-1:0] cur_max_y_index;
    logic             busy;
    logic             frame_done;
    logic             err_short_line;
    logic             err_long_line;
    logic             err_sof;
    logic [15:0]      frame_count;

    axis_frame_gate_ctrl #(
        .BITS  (BITS),
        .IDX_W (IDX_W)
    ) u_dut (
        .aclk            (aclk),
        .areset          (areset),
        .enable          (enable),
        .max_x_index     (max_x_index),
        .max_y_index     (max_y_index),
        .s_axis_tdata    (s_axis_tdata),
        .s_axis_tvalid   (s_axis_tvalid),
        .s_axis_tready   (s_axis_tready),
        .s_axis_tlast    (s_axis_tlast),
        .s_axis_tuser    (s_axis_tuser),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tready   (m_axis_tready),
        .m_axis_tlast    (m_axis_tlast),
        .m_axis_tuser    (m_axis_tuser),
        .cur_max_y_index (cur_max_y_index),
        .busy            (busy),
        .frame_done      (frame_done),
        .err_short_line  (err_short_line),
        .err_long_line   (err_long_line),
        .err_sof         (err_sof),
        .frame_count     (frame_count)
    );

    always #5 aclk = ~aclk;

    int    checks = 0;
    int    errors = 0;
    beat_t stim_q[$];
    beat_t exp_q[$];
    beat_t mon_q[$];
    int    waits_q[$];
    int    n_done = 0, n_short = 0, n_long = 0, n_sof = 0;
    int    e_done = 0, e_short = 0, e_long = 0, e_sof = 0;
    bit    cur_en;
    int    cur_mx, cur_my;
    // stream model: 0 = waiting for SOF, 1 = inside frame, 2 = dropping
    int    m_mode = 0, m_x = 0, m_y = 0, m_mx = 0, m_my = 0;
    bit    m_bad = 1'b0;
    logic [15:0] exp_fc = 16'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    always @(negedge aclk) begin
        if (!areset) begin
            if (m_axis_tvalid && m_axis_tready) begin
                mon_q.push_back({m_axis_tdata, m_axis_tlast, m_axis_tuser});
            end
            if (frame_done)     n_done++;
            if (err_short_line) n_short++;
            if (err_long_line)  n_long++;
            if (err_sof)        n_sof++;
            if (!busy) chk("idle_mvalid", m_axis_tvalid, 1'b0);
            if (busy && s_axis_tvalid && !s_axis_tuser) chk("pass_ready_mirror", s_axis_tready, m_axis_tready);
        end
    end

    // Beat-level view of the gate: what each input beat becomes downstream
    task automatic model_beat(input beat_t b);
        bit again;
        again = 1'b1;
        while (again) begin
            again = 1'b0;
            if (m_mode != 1) begin
                if (b.u && cur_en) begin
                    m_mode = 1; m_x = 0; m_y = 0; m_bad = 1'b0;
                    m_mx = cur_mx; m_my = cur_my;
                    again = 1'b1;
                end
            end else if (b.u && (m_x != 0 || m_y != 0)) begin
                e_sof++;
                m_mode = 2;
                again  = 1'b1;
            end else begin
                exp_q.push_back({b.d, b.l | (m_x == m_mx), b.u});
                if (!b.l) begin
                    if (m_x == m_mx) begin e_long++; m_mode = 2; end
                    else m_x++;
                end else begin
                    if (m_x < m_mx) begin e_short++; m_bad = 1'b1; end
                    m_x = 0;
                    if (m_y == m_my) begin
                        if (!m_bad) begin e_done++; exp_fc = exp_fc + 16'd1; end
                        m_mode = 0;
                    end else m_y++;
                end
            end
        end
    endtask

    task automatic add_line(input int len, input bit sof, input bit wl);
        for (int i = 0; i < len; i++) begin
            beat_t b;
            b.d = BITS'($urandom);
            b.l = wl && (i == len - 1);
            b.u = sof && (i == 0);
            stim_q.push_back(b);
        end
    endtask

    task automatic add_frame(input int mx, input int my);
        for (int y = 0; y <= my; y++) add_line(mx + 1, y == 0, 1'b1);
    endtask

    task automatic add_random_frame(input int mx, input int my);
        int nl;
        nl = ($urandom_range(99) < 80) ? my + 1 : int'($urandom_range(1, my + 2));
        for (int y = 0; y < nl; y++) begin
            int len;
            bit wl;
            len = ($urandom_range(99) < 80) ? mx + 1 : int'($urandom_range(1, mx + 3));
            wl  = ($urandom_range(99) < 95);
            add_line(len, y == 0, wl);
        end
    endtask

    // Starts and ends at posedge+1; geometry is only valid while a SOF is offered
    task automatic drive_beat(input beat_t b, input int gap_pct, input int rdy_pct, output int waits);
        while ($urandom_range(99) < gap_pct) begin
            s_axis_tvalid = 1'b0;
            s_axis_tuser  = 1'($urandom);
            s_axis_tlast  = 1'($urandom);
            m_axis_tready = ($urandom_range(99) < rdy_pct);
            @(posedge aclk); #1;
        end
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = b.d;
        s_axis_tlast  = b.l;
        s_axis_tuser  = b.u;
        if (b.u) begin
            max_x_index = IDX_W'(cur_mx);
            max_y_index = IDX_W'(cur_my);
        end else begin
            max_x_index = IDX_W'($urandom);
            max_y_index = IDX_W'($urandom);
        end
        waits = 0;
        forever begin
            m_axis_tready = ($urandom_range(99) < rdy_pct);
            @(negedge aclk);
            if (s_axis_tready) break;
            waits++;
            if (waits == 200) begin
                chk("handshake_timeout", s_axis_tready, 1'b1);
                break;
            end
            @(posedge aclk); #1;
        end
        @(posedge aclk); #1;
        s_axis_tvalid = 1'b0;
    endtask

    task automatic run_stream(input bit en, input int mx, input int my, input int gap, input int rdy);
        beat_t b;
        int    w;
        enable = en;
        cur_en = en; cur_mx = mx; cur_my = my;
        waits_q.delete();
        while (stim_q.size() > 0) begin
            b = stim_q.pop_front();
            model_beat(b);
            drive_beat(b, gap, rdy, w);
            waits_q.push_back(w);
        end
    endtask

    task automatic settle();
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
    endtask

    task automatic check_results(input string tag);
        int n;
        chk({tag, "_nbeats"}, mon_q.size(), exp_q.size());
        n = (mon_q.size() < exp_q.size()) ? mon_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk({tag, "_beat"}, mon_q[i], exp_q[i]);
        chk({tag, "_done"},  n_done,  e_done);
        chk({tag, "_short"}, n_short, e_short);
        chk({tag, "_long"},  n_long,  e_long);
        chk({tag, "_sof"},   n_sof,   e_sof);
        chk({tag, "_fcount"}, frame_count, exp_fc);
        mon_q.delete(); exp_q.delete();
        n_done = 0; n_short = 0; n_long = 0; n_sof = 0;
        e_done = 0; e_short = 0; e_long = 0; e_sof = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired observed=running required=finished");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        areset        = 1'b1;
        enable        = 1'b0;
        max_x_index   = '0;
        max_y_index   = '0;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b1;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
        m_axis_tready = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        @(negedge aclk);
        chk("rst_s_tready", s_axis_tready, 1'b0);
        chk("rst_m_tvalid", m_axis_tvalid, 1'b0);
        @(posedge aclk); #1;
        areset        = 1'b0;
        s_axis_tvalid = 1'b0;
        @(negedge aclk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_fcount", frame_count, 16'd0);
        chk("rst_cur_max_y", cur_max_y_index, 12'd0);
        chk("rst_pulses", {frame_done, err_short_line, err_long_line, err_sof}, 4'd0);
        @(posedge aclk); #1;

        // Nominal 4x2 frame, sink always ready
        add_frame(3, 1);
        run_stream(1'b1, 3, 1, 0, 100);
        @(negedge aclk);
        chk("t1_frame_done_next", frame_done, 1'b1);
        chk("t1_busy_after", busy, 1'b0);
        chk("t1_cur_max_y", cur_max_y_index, 12'd1);
        chk("t1_sof_stall", waits_q[0], 1);
        chk("t1_no_stall_mid", waits_q[4], 0);
        settle();
        check_results("t1");

        // Same frame under sink back-pressure
        add_frame(3, 1);
        run_stream(1'b1, 3, 1, 0, 50);
        settle();
        check_results("t2");

        // Short first line
        add_line(3, 1'b1, 1'b1);
        add_line(4, 1'b0, 1'b1);
        run_stream(1'b1, 3, 1, 10, 70);
        settle();
        check_results("t3");

        // Long first line, drop until the next good frame
        add_line(6, 1'b1, 1'b0);
        add_line(4, 1'b0, 1'b1);
        add_frame(3, 1);
        run_stream(1'b1, 3, 1, 10, 70);
        settle();
        check_results("t4");

        // SOF arriving at x=2 of line 0
        add_line(2, 1'b1, 1'b0);
        add_frame(3, 1);
        run_stream(1'b1, 3, 1, 0, 100);
        chk("t5_sof_hold", waits_q[2], 2);
        settle();
        check_results("t5");

        // Admission disabled at SOF
        add_frame(3, 1);
        run_stream(1'b0, 3, 1, 10, 70);
        settle();
        check_results("t6");

        // One-pixel frames, then a missing tlast with one-pixel lines
        add_frame(0, 0);
        add_frame(0, 0);
        add_line(3, 1'b1, 1'b1);
        run_stream(1'b1, 0, 0, 0, 100);
        settle();
        check_results("t7");

        for (int f = 0; f < 40; f++) begin
            int mx, my;
            bit en;
            mx = $urandom_range(0, 4);
            my = $urandom_range(0, 3);
            en = ($urandom_range(99) < 85);
            add_random_frame(mx, my);
            run_stream(en, mx, my, 20, 70);
            settle();
            check_results("rnd");
        end

        // Reset in the middle of a line
        add_line(3, 1'b1, 1'b0);
        run_stream(1'b1, 3, 1, 0, 100);
        settle();
        check_results("rst_pre");
        areset        = 1'b1;
        s_axis_tvalid = 1'b1;
        s_axis_tuser  = 1'b0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b1;
        @(negedge aclk);
        chk("midrst_s_tready", s_axis_tready, 1'b0);
        chk("midrst_m_tvalid", m_axis_tvalid, 1'b0);
        @(posedge aclk); #1;
        areset        = 1'b0;
        s_axis_tvalid = 1'b0;
        m_mode = 0;
        exp_fc = 16'd0;
        @(negedge aclk);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_fcount", frame_count, 16'd0);
        chk("midrst_cur_max_y", cur_max_y_index, 12'd0);
        chk("midrst_pulses", {frame_done, err_short_line, err_long_line, err_sof}, 4'd0);
        @(posedge aclk); #1;
        add_frame(1, 0);
        run_stream(1'b1, 1, 0, 0, 100);
        settle();
        check_results("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
